control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_pkg.sv | 26 ++
 rtl/control_fsm_decode.sv | 132 +++++++++++++
 rtl/control_fsm.sv | 76 +++++++
 tb/tb_control_fsm.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: state codes, opcodes and ALU ops.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        StFetch     = 3'b000,
        StDecode    = 3'b001,
        StExecute   = 3'b010,
        StMemory    = 3'b011,
        StWriteback = 3'b100,
        StHalt      = 3'b101,
        StIdle      = 3'b110
    } state_e;

    localparam logic [2:0] OpLda = 3'b000;
    localparam logic [2:0] OpSta = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpJmp = 3'b100;
    localparam logic [2:0] OpJz  = 3'b101;
    localparam logic [2:0] OpNop = 3'b110;
    localparam logic [2:0] OpHlt = 3'b111;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;

endpackage

// File: rtl/control_fsm_decode.sv
// Combinational next-state, retire and datapath-strobe decode for control_fsm.
// Without CONTROL_FSM_WAIT_EN the mem_ready handshake is ignored (treated as always ready).
module control_fsm_decode
    import control_fsm_pkg::*;
(
    input  logic [2:0] state_i,
    input  logic [2:0] opcode_i,
    input  logic       zf_i,
    input  logic       start_i,
    input  logic       resume_i,
    input  logic       mem_ready_i,
    output logic [2:0] state_next_o,
    output logic       retire_o,
    output logic       pc_we_o,
    output logic       pc_jmp_sel_o,
    output logic       ir_we_o,
    output logic       mem_sel_o,
    output logic       mem_we_o,
    output logic       alu_we_o,
    output logic       zf_we_o,
    output logic       a_we_o,
    output logic [2:0] alu_opcode_o,
    output logic       halt_o
);

    state_e cur_state;
    state_e next_state;
    logic   mem_rdy;

    assign cur_state    = state_e'(state_i);
    assign state_next_o = next_state;

`ifdef CONTROL_FSM_WAIT_EN
    assign mem_rdy = mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign mem_rdy          = 1'b1;
`endif

    always_comb begin
        next_state = StIdle;
        retire_o   = 1'b0;
        case (cur_state)
            StIdle:   next_state = start_i ? StFetch : StIdle;
            StFetch:  next_state = mem_rdy ? StDecode : StFetch;
            StDecode: begin
                if (opcode_i == OpHlt) begin
                    next_state = StHalt;
                end else if (opcode_i == OpNop) begin
                    next_state = StFetch;
                    retire_o   = 1'b1;
                end else begin
                    next_state = StExecute;
                end
            end
            StExecute: begin
                case (opcode_i)
                    OpAdd, OpSub: next_state = StWriteback;
                    OpLda, OpSta: next_state = StMemory;
                    OpJmp, OpJz: begin
                        next_state = StFetch;
                        retire_o   = 1'b1;
                    end
                    default:      next_state = StFetch;
                endcase
            end
            StMemory: begin
                if (!mem_rdy) begin
                    next_state = StMemory;
                end else if (opcode_i == OpLda) begin
                    next_state = StWriteback;
                end else begin
                    next_state = StFetch;
                    retire_o   = (opcode_i == OpSta);
                end
            end
            StWriteback: begin
                next_state = StFetch;
                retire_o   = 1'b1;
            end
            StHalt:   next_state = resume_i ? StFetch : StHalt;
            default:  next_state = StIdle;
        endcase
    end

    always_comb begin
        pc_we_o      = 1'b0;
        pc_jmp_sel_o = 1'b0;
        ir_we_o      = 1'b0;
        mem_sel_o    = 1'b0;
        mem_we_o     = 1'b0;
        alu_we_o     = 1'b0;
        zf_we_o      = 1'b0;
        a_we_o       = 1'b0;
        alu_opcode_o = AluAdd;
        halt_o       = 1'b0;
        case (cur_state)
            StFetch: begin
                mem_sel_o = 1'b1;
                ir_we_o   = mem_rdy;
                pc_we_o   = mem_rdy;
            end
            StExecute: begin
                case (opcode_i)
                    OpAdd, OpSub: begin
                        alu_we_o     = 1'b1;
                        zf_we_o      = 1'b1;
                        alu_opcode_o = (opcode_i == OpSub) ? AluSub : AluAdd;
                    end
                    OpJmp: begin
                        pc_we_o      = 1'b1;
                        pc_jmp_sel_o = 1'b1;
                    end
                    OpJz: begin
                        pc_we_o      = zf_i;
                        pc_jmp_sel_o = zf_i;
                    end
                    default: ;
                endcase
            end
            StMemory: begin
                mem_sel_o = 1'b1;
                mem_we_o  = (opcode_i == OpSta) && mem_rdy;
            end
            StWriteback: a_we_o = 1'b1;
            StHalt:      halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM: state register, retired-instruction counter and decode instance.
// Define CONTROL_FSM_WAIT_EN to honour the mem_ready handshake in FETCH and MEMORY.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zf,
    input  logic               start,
    input  logic               resume,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               pc_we,
    output logic               pc_jmp_sel,
    output logic               ir_we,
    output logic               mem_sel,
    output logic               mem_we,
    output logic               alu_we,
    output logic               zf_we,
    output logic               a_we,
    output logic [2:0]         alu_opcode,
    output logic               halt,
    output logic [CNT_W-1:0]   retired
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic [2:0]       opcode;
    logic             unused_operand;

    assign opcode         = instr[INSTR_W-1 -: 3];
    assign unused_operand = ^instr[INSTR_W-4:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Counter wraps naturally at 2^CNT_W.
    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

    control_fsm_decode u_decode (
        .state_i      (state_q),
        .opcode_i     (opcode),
        .zf_i         (zf),
        .start_i      (start),
        .resume_i     (resume),
        .mem_ready_i  (mem_ready),
        .state_next_o (state_d),
        .retire_o     (retire),
        .pc_we_o      (pc_we),
        .pc_jmp_sel_o (pc_jmp_sel),
        .ir_we_o      (ir_we),
        .mem_sel_o    (mem_sel),
        .mem_we_o     (mem_we),
        .alu_we_o     (alu_we),
        .zf_we_o      (zf_we),
        .a_we_o       (a_we),
        .alu_opcode_o (alu_opcode),
        .halt_o       (halt)
    );

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: directed per-cycle expectations queued by the stimulus,
// checked by an independent negedge monitor; a CNT_W=4 twin exercises counter wrap.
module tb_control_fsm;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_DEC   = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;
    localparam logic [2:0] ST_IDLE  = 3'd6;

    // {pc_we, pc_jmp_sel, ir_we, mem_sel, mem_we, alu_we, zf_we, a_we}
    localparam logic [7:0] S_NONE   = 8'b0000_0000;
    localparam logic [7:0] S_FETCH  = 8'b1011_0000;
    localparam logic [7:0] S_MEMSEL = 8'b0001_0000;
    localparam logic [7:0] S_STORE  = 8'b0001_1000;
    localparam logic [7:0] S_ALU    = 8'b0000_0110;
    localparam logic [7:0] S_WB     = 8'b0000_0001;
    localparam logic [7:0] S_JUMP   = 8'b1100_0000;

    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  stb;
        logic [2:0]  alu;
        logic        hlt;
        logic [15:0] ret;
    } obs_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  instr;
    logic        zf, start, resume, mem_ready;

    logic [2:0]  state, alu_opcode;
    logic        pc_we, pc_jmp_sel, ir_we, mem_sel, mem_we, alu_we, zf_we, a_we, halt;
    logic [15:0] retired;

    logic [2:0]  state4, alu_opcode4;
    logic        pc_we4, pc_jmp_sel4, ir_we4, mem_sel4, mem_we4, alu_we4, zf_we4, a_we4, halt4;
    logic [3:0]  retired4;

    obs_t        sb[$];
    obs_t        exp_o, act_o, exp4_o, act4_o;
    logic [15:0] exp_ret;
    int          n_vec;
    int          n_bad;

    control_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .zf         (zf),
        .start      (start),
        .resume     (resume),
        .mem_ready  (mem_ready),
        .state      (state),
        .pc_we      (pc_we),
        .pc_jmp_sel (pc_jmp_sel),
        .ir_we      (ir_we),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
        .alu_we     (alu_we),
        .zf_we      (zf_we),
        .a_we       (a_we),
        .alu_opcode (alu_opcode),
        .halt       (halt),
        .retired    (retired)
    );

    control_fsm #(.INSTR_W(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .zf         (zf),
        .start      (start),
        .resume     (resume),
        .mem_ready  (mem_ready),
        .state      (state4),
        .pc_we      (pc_we4),
        .pc_jmp_sel (pc_jmp_sel4),
        .ir_we      (ir_we4),
        .mem_sel    (mem_sel4),
        .mem_we     (mem_we4),
        .alu_we     (alu_we4),
        .zf_we      (zf_we4),
        .a_we       (a_we4),
        .alu_opcode (alu_opcode4),
        .halt       (halt4),
        .retired    (retired4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: got no end of stimulus by t=50000, want finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_o  = sb.pop_front();
            act_o  = {state, pc_we, pc_jmp_sel, ir_we, mem_sel, mem_we, alu_we, zf_we, a_we,
                      alu_opcode, halt, retired};
            exp4_o = exp_o;
            exp4_o.ret = {12'd0, exp_o.ret[3:0]};
            act4_o = {state4, pc_we4, pc_jmp_sel4, ir_we4, mem_sel4, mem_we4, alu_we4, zf_we4,
                      a_we4, alu_opcode4, halt4, 12'd0, retired4};
            n_vec++;
            if (act_o !== exp_o) begin
                n_bad++;
                $display("FAIL cycle t=%0t cnt16: got st=%0d stb=%b alu=%0d halt=%b ret=%0d, want st=%0d stb=%b alu=%0d halt=%b ret=%0d",
                         $time, act_o.st, act_o.stb, act_o.alu, act_o.hlt, act_o.ret,
                         exp_o.st, exp_o.stb, exp_o.alu, exp_o.hlt, exp_o.ret);
            end
            n_vec++;
            if (act4_o !== exp4_o) begin
                n_bad++;
                $display("FAIL cycle t=%0t cnt4: got st=%0d stb=%b alu=%0d halt=%b ret=%0d, want st=%0d stb=%b alu=%0d halt=%b ret=%0d",
                         $time, act4_o.st, act4_o.stb, act4_o.alu, act4_o.hlt, act4_o.ret,
                         exp4_o.st, exp4_o.stb, exp4_o.alu, exp4_o.hlt, exp4_o.ret);
            end
        end
    end

    // Queue the expected outputs for the current cycle, then advance one clock.
    task automatic cyc(input logic [2:0] st, input logic [7:0] stb, input logic [2:0] alu,
                       input logic hlt);
        obs_t e;
        e.st  = st;
        e.stb = stb;
        e.alu = alu;
        e.hlt = hlt;
        e.ret = exp_ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        exp_ret   = 16'd0;
        reset_n   = 1'b0;
        instr     = 8'h00;
        zf        = 1'b0;
        start     = 1'b1;
        resume    = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(ST_IDLE, S_NONE, 3'd0, 1'b0);
        reset_n = 1'b1;
        start   = 1'b0;
        cyc(ST_IDLE, S_NONE, 3'd0, 1'b0);

        // ADD
        instr = 8'b01000001;
        start = 1'b1;
        cyc(ST_IDLE, S_NONE, 3'd0, 1'b0);
        start = 1'b0;
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        cyc(ST_EXEC,  S_ALU,   3'd0, 1'b0);
        cyc(ST_WB,    S_WB,    3'd0, 1'b0);
        exp_ret = 16'd1;

        // SUB
        instr = 8'b01100000;
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        cyc(ST_EXEC,  S_ALU,   3'd1, 1'b0);
        cyc(ST_WB,    S_WB,    3'd0, 1'b0);
        exp_ret = 16'd2;

        // LDA with memory wait states
        instr = 8'b00000011;
`ifdef CONTROL_FSM_WAIT_EN
        mem_ready = 1'b0;
        cyc(ST_FETCH, S_MEMSEL, 3'd0, 1'b0);
        mem_ready = 1'b1;
`endif
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        cyc(ST_EXEC,  S_NONE,  3'd0, 1'b0);
        mem_ready = 1'b0;
`ifdef CONTROL_FSM_WAIT_EN
        repeat (3) cyc(ST_MEM, S_MEMSEL, 3'd0, 1'b0);
        mem_ready = 1'b1;
`endif
        cyc(ST_MEM, S_MEMSEL, 3'd0, 1'b0);
        mem_ready = 1'b1;
        cyc(ST_WB,  S_WB,     3'd0, 1'b0);
        exp_ret = 16'd3;

        // STA
        instr = 8'b00100101;
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        cyc(ST_EXEC,  S_NONE,  3'd0, 1'b0);
        cyc(ST_MEM,   S_STORE, 3'd0, 1'b0);
        exp_ret = 16'd4;

        // JZ not taken, then taken
        instr = 8'b10100010;
        zf    = 1'b0;
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        cyc(ST_EXEC,  S_NONE,  3'd0, 1'b0);
        exp_ret = 16'd5;
        zf      = 1'b1;
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        cyc(ST_EXEC,  S_JUMP,  3'd0, 1'b0);
        exp_ret = 16'd6;
        zf      = 1'b0;

        // JMP
        instr = 8'b10000111;
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        cyc(ST_EXEC,  S_JUMP,  3'd0, 1'b0);
        exp_ret = 16'd7;

        // HLT: start must not wake it, resume does; no retire
        instr = 8'b11100000;
        cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
        cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
        start = 1'b1;
        repeat (10) cyc(ST_HALT, S_NONE, 3'd0, 1'b1);
        start  = 1'b0;
        resume = 1'b1;
        cyc(ST_HALT, S_NONE, 3'd0, 1'b1);
        resume = 1'b0;

        // 16 NOPs: 7 -> 23, so the 4-bit twin wraps 15 -> 0
        instr = 8'b11000000;
        for (int i = 0; i < 16; i++) begin
            cyc(ST_FETCH, S_FETCH, 3'd0, 1'b0);
            cyc(ST_DEC,   S_NONE,  3'd0, 1'b0);
            exp_ret = exp_ret + 16'd1;
        end

        // Asynchronous reset in the middle of a FETCH cycle
        #1;
        chk("pre-reset state", {13'd0, state}, {13'd0, ST_FETCH});
        chk("pre-reset retired", retired, 16'd23);
        chk("pre-reset retired4", {12'd0, retired4}, 16'd7);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async reset state", {13'd0, state}, {13'd0, ST_IDLE});
        chk("async reset retired", retired, 16'd0);
        chk("async reset retired4", {12'd0, retired4}, 16'd0);
        chk("async reset strobes",
            {8'd0, pc_we, pc_jmp_sel, ir_we, mem_sel, mem_we, alu_we, zf_we, a_we}, 16'd0);
        chk("async reset halt", {15'd0, halt}, 16'd0);
        @(posedge clk);
        #1;
        exp_ret = 16'd0;
        reset_n = 1'b1;
        cyc(ST_IDLE, S_NONE, 3'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
